// File: rtl/pfm_channel_sequencer.sv
// Channel scheduler for the 3-kernel PFM engine: fetch tile+kernels, pulse engine reset, wait, accumulate.
// Build option PFM_RELU_EN: fm* present max(acc, 0); the accumulators themselves stay signed.
module pfm_channel_sequencer #(
    parameter int IP_SIZE      = 6,
    parameter int KERNEL_SIZE  = 3,
    parameter int NUM_CH       = 3,
    parameter int TIMEOUT      = 1024,
    localparam int OP_SIZE     = IP_SIZE - KERNEL_SIZE + 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IP_W        = 16 * IP_SIZE * IP_SIZE,
    localparam int K_W         = 16 * KERNEL_SIZE * KERNEL_SIZE,
    localparam int OP_W        = 16 * OP_SIZE * OP_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            ch_req,
    output logic [CH_W-1:0] ch_idx,
    input  logic            ch_valid,
    input  logic [IP_W-1:0] ch_ipf,
    input  logic [K_W-1:0]  ch_K1f,
    input  logic [K_W-1:0]  ch_K2f,
    input  logic [K_W-1:0]  ch_K3f,
    output logic            eng_rst,
    output logic [IP_W-1:0] eng_ipf,
    output logic [K_W-1:0]  eng_K1f,
    output logic [K_W-1:0]  eng_K2f,
    output logic [K_W-1:0]  eng_K3f,
    input  logic [OP_W-1:0] eng_IK1,
    input  logic [OP_W-1:0] eng_IK2,
    input  logic [OP_W-1:0] eng_IK3,
    input  logic            eng_resting,
    output logic [OP_W-1:0] fm1,
    output logic [OP_W-1:0] fm2,
    output logic [OP_W-1:0] fm3,
    output logic            fm_valid
);

    localparam int NE    = OP_SIZE * OP_SIZE;
    localparam int E_W   = (NE > 1) ? $clog2(NE) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [E_W-1:0]   LAST_E   = E_W'(NE - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ENG_RST, S_ENG_RUN, S_ACCUM, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  ch_q;
    logic [E_W-1:0]   e_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q, fm_valid_q;
    logic             go, timeout_hit;
    logic [15:0]      acc_q [3][NE];
    logic [OP_W-1:0]  ik [3];

    assign ik[0] = eng_IK1;
    assign ik[1] = eng_IK2;
    assign ik[2] = eng_IK3;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] s;
        s = $signed({a[15], a}) + $signed({b[15], b});
        if (s > 17'sd32767)       return 16'h7fff;
        else if (s < -17'sd32768) return 16'h8000;
        else                      return s[15:0];
    endfunction

    function automatic logic [15:0] out_view(input logic [15:0] a);
`ifdef PFM_RELU_EN
        return a[15] ? 16'h0000 : a;
`else
        return a;
`endif
    endfunction

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        go          = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                go      = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH:   if (ch_valid) state_d = S_ENG_RST;
            S_ENG_RST: if (cnt_q == CNT_W'(1)) state_d = S_ENG_RUN;
            S_ENG_RUN: begin
                // The first run cycle still sees the resting flag left over from before reset.
                if (cnt_q != '0 && eng_resting) begin
                    state_d = S_ACCUM;
                end else if (cnt_q == LAST_RUN) begin
                    timeout_hit = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_ACCUM:   if (e_q == LAST_E) state_d = (ch_q == LAST_CH) ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: the accumulator array is reset because fm* must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q       <= '0;
            e_q        <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            fm_valid_q <= 1'b0;
            eng_ipf    <= '0;
            eng_K1f    <= '0;
            eng_K2f    <= '0;
            eng_K3f    <= '0;
            for (int m = 0; m < 3; m++)
                for (int e = 0; e < NE; e++) acc_q[m][e] <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (go) begin
                    ch_q       <= '0;
                    e_q        <= '0;
                    err_q      <= 1'b0;
                    fm_valid_q <= 1'b0;
                    for (int m = 0; m < 3; m++)
                        for (int e = 0; e < NE; e++) acc_q[m][e] <= '0;
                end
                S_FETCH: if (ch_valid) begin
                    eng_ipf <= ch_ipf;
                    eng_K1f <= ch_K1f;
                    eng_K2f <= ch_K2f;
                    eng_K3f <= ch_K3f;
                    cnt_q   <= '0;
                end
                S_ENG_RST: cnt_q <= (cnt_q == CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
                S_ENG_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (timeout_hit) err_q <= 1'b1;
                end
                S_ACCUM: begin
                    for (int m = 0; m < 3; m++)
                        acc_q[m][e_q] <= sat_add(acc_q[m][e_q], ik[m][16*int'(e_q) +: 16]);
                    e_q <= (e_q == LAST_E) ? '0 : e_q + E_W'(1);
                    if (e_q == LAST_E && ch_q != LAST_CH) ch_q <= ch_q + CH_W'(1);
                end
                default: ;
            endcase
            if (state_d == S_DONE) fm_valid_q <= 1'b1;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign ch_req   = (state_q == S_FETCH);
    assign ch_idx   = ch_q;
    assign eng_rst  = !(state_q == S_ENG_RUN || state_q == S_ACCUM);
    assign err      = err_q;
    assign fm_valid = fm_valid_q;

    always_comb begin
        fm1 = '0;
        fm2 = '0;
        fm3 = '0;
        for (int e = 0; e < NE; e++) begin
            fm1[16*e +: 16] = out_view(acc_q[0][e]);
            fm2[16*e +: 16] = out_view(acc_q[1][e]);
            fm3[16*e +: 16] = out_view(acc_q[2][e]);
        end
    end

endmodule

// File: tb/tb_pfm_channel_sequencer.sv
// Directed bench for pfm_channel_sequencer: vector table of whole runs plus reset/stall/timeout sequences.
module tb_pfm_channel_sequencer;

    localparam int IP_SIZE     = 6;
    localparam int KERNEL_SIZE = 3;
    localparam int NUM_CH      = 3;
    localparam int TIMEOUT     = 16;
    localparam int OP_SIZE     = IP_SIZE - KERNEL_SIZE + 1;
    localparam int NE          = OP_SIZE * OP_SIZE;
    localparam int IP_N        = IP_SIZE * IP_SIZE;
    localparam int K_N         = KERNEL_SIZE * KERNEL_SIZE;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, ch_valid = 1'b0;
    logic busy, done, err, ch_req, eng_rst, eng_resting, fm_valid;
    logic [1:0]        ch_idx;
    logic [16*IP_N-1:0] ch_ipf = '0, eng_ipf;
    logic [16*K_N-1:0]  ch_K1f = '0, ch_K2f = '0, ch_K3f = '0, eng_K1f, eng_K2f, eng_K3f;
    logic [16*NE-1:0]   eng_IK1, eng_IK2, eng_IK3, fm1, fm2, fm3;

    logic [15:0] ik1_v = '0, ik2_v = '0, ik3_v = '0;
    bit          hang = 1'b0;
    int          run_cnt = 0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    pfm_channel_sequencer #(
        .IP_SIZE(IP_SIZE), .KERNEL_SIZE(KERNEL_SIZE), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .ch_req(ch_req), .ch_idx(ch_idx), .ch_valid(ch_valid), .ch_ipf(ch_ipf),
        .ch_K1f(ch_K1f), .ch_K2f(ch_K2f), .ch_K3f(ch_K3f), .eng_rst(eng_rst),
        .eng_ipf(eng_ipf), .eng_K1f(eng_K1f), .eng_K2f(eng_K2f), .eng_K3f(eng_K3f),
        .eng_IK1(eng_IK1), .eng_IK2(eng_IK2), .eng_IK3(eng_IK3), .eng_resting(eng_resting),
        .fm1(fm1), .fm2(fm2), .fm3(fm3), .fm_valid(fm_valid)
    );

    // Engine stub: rests 10 cycles after its reset falls and holds constant partial maps.
    assign eng_IK1 = {NE{ik1_v}};
    assign eng_IK2 = {NE{ik2_v}};
    assign eng_IK3 = {NE{ik3_v}};
    assign eng_resting = !eng_rst && !hang && (run_cnt >= 10);

    always @(posedge clk) begin
        if (eng_rst)            run_cnt <= 0;
        else if (run_cnt < 1000) run_cnt <= run_cnt + 1;
    end

    typedef struct {
        int ik1, ik2, ik3;
        int delay1;
        bit hang, start_accum, exp_err;
        int exp1, exp2, exp3;
        int mid1, mid2, mid3;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int view(input int v);
`ifdef PFM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // First element that differs from exp, or element 0 when the whole map matches.
    function automatic int map_val(input logic [16*NE-1:0] m, input int exp);
        int x;
        for (int e = 0; e < NE; e++) begin
            x = int'($signed(m[16*e +: 16]));
            if (x != exp) return x;
        end
        return int'($signed(m[15:0]));
    endfunction

    task automatic check_maps(input string tag, input int e1, input int e2, input int e3);
        check({tag, ".fm1"}, map_val(fm1, view(e1)), view(e1));
        check({tag, ".fm2"}, map_val(fm2, view(e2)), view(e2));
        check({tag, ".fm3"}, map_val(fm3, view(e3)), view(e3));
    endtask

    task automatic serve_channel(input string tag, input int c, input int d, input bit start_accum,
                                 input int abort_at, output int hi, output int lo);
        int n;
        logic [15:0] p;
        n = 0;
        while (!ch_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".ch_req"}, ch_req, 1);
        check({tag, ".ch_idx"}, ch_idx, c);
        for (int k = 0; k < d; k++) begin
            @(negedge clk);
            check({tag, ".stall_req"}, ch_req, 1);
            check({tag, ".stall_idx"}, ch_idx, c);
        end
        p = 16'h1000 + 16'(c);
        ch_ipf   = {IP_N{p}};
        ch_K1f   = {K_N{p + 16'h0100}};
        ch_K2f   = {K_N{p + 16'h0200}};
        ch_K3f   = {K_N{p + 16'h0300}};
        ch_valid = 1'b1;
        @(negedge clk);
        ch_valid = 1'b0;
        ch_ipf   = '0;
        ch_K3f   = '0;
        check({tag, ".req_drop"}, ch_req, 0);
        check({tag, ".eng_ipf"}, int'(eng_ipf == {IP_N{p}}), 1);
        check({tag, ".eng_K3f"}, int'(eng_K3f == {K_N{p + 16'h0300}}), 1);
        hi = 0;
        while (eng_rst && hi < 50) begin
            @(negedge clk);
            hi++;
        end
        lo = 0;
        while (!eng_rst && lo < 200 && lo != abort_at) begin
            start = start_accum && (lo == 15);
            @(negedge clk);
            lo++;
        end
        start = 1'b0;
    endtask

    task automatic run(input vec_t v, input string tag);
        int hi, lo;
        ik1_v = 16'(v.ik1);
        ik2_v = 16'(v.ik2);
        ik3_v = 16'(v.ik3);
        hang  = v.hang;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy_on"}, busy, 1);
        check({tag, ".err_clr"}, err, 0);
        check({tag, ".fmv_clr"}, fm_valid, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == NUM_CH - 1) check_maps({tag, ".mid"}, v.mid1, v.mid2, v.mid3);
            serve_channel(tag, c, (c == 1) ? v.delay1 : 0, v.start_accum && (c == 0), -1, hi, lo);
            check({tag, ".rst_cycles"}, hi, 2);
            if (v.hang) begin
                check({tag, ".timeout_cycles"}, lo, TIMEOUT);
                break;
            end
            check({tag, ".run_accum_cycles"}, lo, 27);
        end
        check({tag, ".done"}, done, 1);
        check({tag, ".fmv"}, fm_valid, 1);
        check({tag, ".busy_done"}, busy, 1);
        check({tag, ".err"}, err, v.exp_err);
        check_maps(tag, v.exp1, v.exp2, v.exp3);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".busy_off"}, busy, 0);
        check({tag, ".fmv_hold"}, fm_valid, 1);
        check({tag, ".err_hold"}, err, v.exp_err);
        check({tag, ".eng_rst_idle"}, eng_rst, 1);
    endtask

    initial begin
        int hi, lo;
        vecs[0] = '{4096, 0, -1000, 0, 0, 0, 0, 12288, 0, -3000, 8192, 0, -2000};
        vecs[1] = '{20000, -20000, 0, 0, 0, 0, 0, 32767, -32768, 0, 32767, -32768, 0};
        vecs[2] = '{4096, 0, -1000, 5, 0, 0, 0, 12288, 0, -3000, 8192, 0, -2000};
        vecs[3] = '{100, 100, 100, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{4096, 0, -1000, 0, 0, 1, 0, 12288, 0, -3000, 8192, 0, -2000};
        vecs[5] = '{0, 0, -4096, 0, 0, 0, 0, 0, 0, -12288, 0, 0, -8192};

        repeat (2) @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.err", err, 0);
        check("reset.ch_req", ch_req, 0);
        check("reset.fm_valid", fm_valid, 0);
        check("reset.eng_rst", eng_rst, 1);
        check("reset.eng_ipf", int'(eng_ipf == '0), 1);
        check_maps("reset", 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("vec%0d", i));

        // Async reset in the middle of channel 1's engine run, then a clean rerun.
        ik1_v = 16'd4096;
        ik2_v = 16'd0;
        ik3_v = 16'(-1000);
        hang  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve_channel("arst", 0, 0, 1'b0, -1, hi, lo);
        serve_channel("arst", 1, 0, 1'b0, 4, hi, lo);
        check("arst.pre_busy", busy, 1);
        check("arst.pre_fm1", map_val(fm1, view(4096)), view(4096));
        #2 rst = 1'b0;
        #1;
        check("arst.busy", busy, 0);
        check("arst.ch_req", ch_req, 0);
        check("arst.eng_rst", eng_rst, 1);
        check("arst.fm_valid", fm_valid, 0);
        check_maps("arst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        run(vecs[0], "rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pfm_channel_sequencer.md
Name: pfm_channel_sequencer

Overview:
Multi-channel scheduler for the partial-feature-map engine (3 kernels, Q1.15). For each of NUM_CH input channels it:
- fetches one IP_SIZE² input tile and three KERNEL_SIZE² kernels from an upstream buffer,
- restarts the engine and waits for its resting flag,
- serially accumulates the engine's three partial maps into full feature maps.

It sits between the tile/weight buffer and the downstream pooling/activation stage.

Parameters:
IP_SIZE, 6, input tile edge length
KERNEL_SIZE, 3, kernel edge length
OP_SIZE, IP_SIZE-KERNEL_SIZE+1, output map edge (derived; do not override)
NUM_CH, 3, number of input channels accumulated per run
TIMEOUT, 1024, max cycles in ENG_RUN before error

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a run
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse at end of run
err  out  1  engine timeout seen in last run; held until next accepted start
ch_req  out  1  channel data request
ch_idx  out  clog2(NUM_CH)  channel being requested
ch_valid  in  1  channel data valid; qualifies ch_ipf/ch_K*f
ch_ipf  in  16*IP_SIZE²  input tile
ch_K1f, ch_K2f, ch_K3f  in  16*KERNEL_SIZE² each  kernels
eng_rst  out  1  engine reset, active-high
eng_ipf  out  16*IP_SIZE²  registered tile to engine
eng_K1f, eng_K2f, eng_K3f  out  16*KERNEL_SIZE² each  registered kernels
eng_IK1, eng_IK2, eng_IK3  in  16*OP_SIZE² each  engine partial maps
eng_resting  in  1  engine finished
fm1, fm2, fm3  out  16*OP_SIZE² each  accumulated maps, signed Q1.15
fm_valid  out  1  fm* final; high from DONE until next accepted start

Behaviour:
- Reset (async, rst=0): state IDLE; busy, done, err, ch_req, fm_valid = 0; eng_rst = 1; eng_* data, fm*, counters = 0.
- IDLE: eng_rst=1. start=1 → clear accumulators, fm_valid, err; ch=0; go to FETCH.
- start while busy is ignored.
- FETCH:
  - ch_req=1 and ch_idx=ch; both held stable until ch_valid.
  - On ch_valid: register ch_* into eng_*, drop ch_req the next cycle, go to ENG_RST.
- ENG_RST: eng_rst=1 for exactly 2 cycles, then ENG_RUN.
- ENG_RUN:
  - eng_rst=0.
  - eng_resting is ignored in the first cycle, then sampled every cycle.
  - eng_resting=1 → ACCUM.
  - Cycle counter reaching TIMEOUT → err=1, go to DONE, skipping the remaining channels.
- ACCUM:
  - Element index e = 0..OP_SIZE²-1, one element per cycle, all three maps in parallel.
  - acc[e] = sat16(acc[e] + IK[e]): 17-bit signed sum, clamped to [-32768, 32767].
  - After the last e: if ch == NUM_CH-1 go to DONE, else ch++ and go to FETCH.
- DONE (1 cycle): done=1, fm_valid=1, busy=0 on exit, eng_rst=1; then IDLE.
- Channel latency: ch_valid wait + 1 + 2 + engine cycles + OP_SIZE².
- done asserts the cycle after the final ACCUM element.
- fm* are valid only while fm_valid=1; during accumulation they show running values.
- eng_IK* must not change during ACCUM; the sequencer relies on the engine holding its outputs while resting.

Optional Feature:
PFM_RELU_EN
- Defined: fm* outputs are max(acc, 0) per element, computed combinationally at the output; accumulation itself stays signed.
- Undefined: fm* present the raw signed accumulators.

Test Plan:
1. NUM_CH=3, stub engine resting 10 cycles after eng_rst falls; IK1=4096, IK2=0, IK3=-1000 every element → fm1=12288, fm2=0, fm3=-3000; done pulses once; ch_idx sequence 0,1,2.
2. Saturation: IK1=20000 and IK2=-20000 for all channels → fm1=32767, fm2=-32768 after channel 1, unchanged after channel 2.
3. Stalled fetch: ch_valid delayed 5 cycles on channel 1 → ch_req high and ch_idx=1 steady for 5 cycles; result identical to test 1.
4. Timeout: TIMEOUT=16, eng_resting tied 0 → err=1 and done 16 cycles after ENG_RUN entry; fm_valid=1; next start clears err.
5. Async reset at an ENG_RUN cycle → busy, ch_req, fm* zero immediately, eng_rst=1; a new start runs test 1 correctly. Also, start pulsed during ACCUM → ignored, exactly one done.
6. PFM_RELU_EN defined, IK3=-4096 ×3 → fm3 reads 0. Undefined → fm3 reads -12288.
